// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the hazard/forward logic and by EX-side control.
// Contents: base opcode constants, the scoreboard entry layout, and the
// forward-select encoding constant for "take operand from register file".
package riscv_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  // Forward select 0 means "no bypass"; k+1 selects scoreboard entry k.
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       is_load;
    logic [4:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/rv_inst_decode.sv
// Register-usage decoder for RV32I instructions.
// Ports:
//   inst      in   32-bit instruction word
//   uses_rs1  out  instruction reads rs1
//   uses_rs2  out  instruction reads rs2
//   wr_rd     out  instruction writes rd
//   is_load   out  instruction is a LOAD (data arrives late)
//   rs1/rs2/rd out register fields, passed through unconditionally
// Unknown opcodes read nothing and write nothing.
module rv_inst_decode
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        wr_rd,
  output logic        is_load,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic [6:0] opcode;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wr_rd    = 1'b0;
    is_load  = 1'b0;
    unique case (opcode)
      LUI, AUIPC, JAL: wr_rd = 1'b1;
      JALR: begin
        wr_rd    = 1'b1;
        uses_rs1 = 1'b1;
      end
      BRANCH, STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      LOAD: begin
        wr_rd    = 1'b1;
        uses_rs1 = 1'b1;
        is_load  = 1'b1;
      end
      OP_IMM: begin
        wr_rd    = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP: begin
        wr_rd    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the ID stage.
// Keeps a shift-register scoreboard of in-flight destinations for the stages
// after ID (entry 0 = EX) and compares the ID instruction's sources against it.
// Ports:
//   clk, rst_n  pipeline clock, async active-low reset
//   id_valid    id_inst holds a real instruction
//   id_inst     instruction in ID
//   flush       redirect: kill ID and the instruction in EX
//   fwd_rs1/2   0 = register file, k+1 = bypass from entry k
//   stall       hold PC and IF/ID, insert bubble into EX
//   stall_cnt   saturating count of stall cycles
module hazard_forward_unit
  import riscv_pkg::*;
#(
  parameter  int unsigned STAGES     = 3,
  parameter  int unsigned LOAD_READY = 1,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W      = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_rs1,
  output logic [SEL_W-1:0]  fwd_rs2,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (STAGES < 2 || LOAD_READY == 0 || LOAD_READY >= STAGES) begin : g_bad_params
    $error("hazard_forward_unit: requires STAGES>=2 and 0<LOAD_READY<STAGES");
  end

  logic       uses_rs1, uses_rs2, wr_rd, is_load;
  logic [4:0] rs1, rs2, rd;

  rv_inst_decode u_decode (
    .inst     (id_inst),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .wr_rd    (wr_rd),
    .is_load  (is_load),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd)
  );

  sb_entry_t        sb [STAGES];
  logic [STAGES-1:0] hit1, hit2;

  for (genvar k = 0; k < STAGES; k++) begin : g_cmp
    logic producer;
    assign producer = id_valid && sb[k].valid && sb[k].wr && (sb[k].rd != 5'd0);
    assign hit1[k]  = producer && uses_rs1 && (sb[k].rd == rs1);
    assign hit2[k]  = producer && uses_rs2 && (sb[k].rd == rs2);
  end

  logic [SEL_W-1:0] sel1, sel2;
  logic             load_use1, load_use2;

  // Scan oldest to youngest so the youngest (lowest index) hit is the last write.
  always_comb begin
    sel1      = SEL_W'(FWD_RF);
    sel2      = SEL_W'(FWD_RF);
    load_use1 = 1'b0;
    load_use2 = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (hit1[STAGES-1-i]) begin
        sel1      = SEL_W'(STAGES - i);
        load_use1 = sb[STAGES-1-i].is_load && ((STAGES - 1 - i) < LOAD_READY);
      end
      if (hit2[STAGES-1-i]) begin
        sel2      = SEL_W'(STAGES - i);
        load_use2 = sb[STAGES-1-i].is_load && ((STAGES - 1 - i) < LOAD_READY);
      end
    end
  end

  always_comb begin
    stall   = (load_use1 || load_use2) && !flush;
    fwd_rs1 = stall ? SEL_W'(FWD_RF) : sel1;
    fwd_rs2 = stall ? SEL_W'(FWD_RF) : sel2;
  end

  sb_entry_t new_entry;

  always_comb begin
    new_entry = '0;
    if (id_valid && !stall && !flush) begin
      new_entry.valid   = 1'b1;
      new_entry.wr      = wr_rd;
      new_entry.is_load = is_load;
      new_entry.rd      = rd;
    end
  end

  // A flush kills the instruction leaving EX, so entry 1 receives a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        sb[k] <= '0;
      end
    end else begin
      sb[0] <= new_entry;
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (k == 1 && flush) begin
          sb[k] <= '0;
        end else begin
          sb[k] <= sb[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        flush;

  logic [1:0]  fwd1, fwd2, fwd1b, fwd2b;
  logic        stall, stallb;
  logic [15:0] cnt;
  logic [1:0]  cntb;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_inst (id_inst), .flush (flush),
    .fwd_rs1 (fwd1), .fwd_rs2 (fwd2), .stall (stall), .stall_cnt (cnt)
  );

  hazard_forward_unit #(.CNT_W (2)) dut_small (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_inst (id_inst), .flush (flush),
    .fwd_rs1 (fwd1b), .fwd_rs2 (fwd2b), .stall (stallb), .stall_cnt (cntb)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int rd;
  } rec_t;

  rec_t pipe[$];
  int   m_cnt;
  int   e_fwd1, e_fwd2;
  bit   e_stall;

  function automatic void classify(input logic [31:0] ins, output bit wr, output bit r1,
                                   output bit r2, output bit ld);
    wr = 0; r1 = 0; r2 = 0; ld = 0;
    case (ins[6:0])
      7'h37, 7'h17, 7'h6f: wr = 1;
      7'h67:               begin wr = 1; r1 = 1; end
      7'h63, 7'h23:        begin r1 = 1; r2 = 1; end
      7'h03:               begin wr = 1; r1 = 1; ld = 1; end
      7'h13:               begin wr = 1; r1 = 1; end
      7'h33:               begin wr = 1; r1 = 1; r2 = 1; end
      default: ;
    endcase
  endfunction

  // Index of the youngest in-flight producer of src, or -1.
  function automatic int producer_of(input int src);
    if (src == 0) return -1;
    foreach (pipe[k]) if (pipe[k].v && pipe[k].wr && pipe[k].rd == src) return k;
    return -1;
  endfunction

  function automatic void model_reset();
    pipe.delete();
    repeat (3) pipe.push_back('{v: 0, wr: 0, ld: 0, rd: 0});
    m_cnt   = 0;
    e_stall = 0;
  endfunction

  function automatic void model_expect(input bit v, input logic [31:0] ins, input bit fl);
    bit wr, r1, r2, ld;
    int w1, w2;
    classify(ins, wr, r1, r2, ld);
    w1 = (v && r1) ? producer_of(int'(ins[19:15])) : -1;
    w2 = (v && r2) ? producer_of(int'(ins[24:20])) : -1;
    e_stall = !fl && ((w1 == 0 && pipe[0].ld) || (w2 == 0 && pipe[0].ld));
    e_fwd1  = e_stall ? 0 : w1 + 1;
    e_fwd2  = e_stall ? 0 : w2 + 1;
  endfunction

  function automatic void model_advance(input bit v, input logic [31:0] ins, input bit fl);
    rec_t n;
    bit wr, r1, r2, ld;
    classify(ins, wr, r1, r2, ld);
    n = '{v: (v && !e_stall && !fl), wr: wr, ld: ld, rd: int'(ins[11:7])};
    if (fl) pipe[0].v = 0;
    pipe.push_front(n);
    void'(pipe.pop_back());
    if (e_stall && m_cnt < 65535) m_cnt++;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fwd_rs1", 32'(fwd1), 32'(e_fwd1));
    chk("fwd_rs2", 32'(fwd2), 32'(e_fwd2));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("stall_cnt", 32'(cnt), 32'(m_cnt));
    chk("small_fwd_rs1", 32'(fwd1b), 32'(e_fwd1));
    chk("small_stall", 32'(stallb), 32'(e_stall));
    chk("small_stall_cnt", 32'(cntb), 32'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic step(input bit v, input logic [31:0] ins, input bit fl);
    id_valid = v; id_inst = ins; flush = fl;
    @(negedge clk);
    model_expect(v, ins, fl);
    check_all();
    @(posedge clk);
    #1;
    model_advance(v, ins, fl);
  endtask

  // Presents ins until it is no longer stalled, as the IF/ID register would.
  task automatic issue(input logic [31:0] ins);
    int guard = 0;
    do begin
      step(1, ins, 0);
      guard++;
    end while (e_stall && guard < 4);
  endtask

  function automatic logic [31:0] addi(input int rd_, input int rs1_, input int imm);
    return {12'(imm), 5'(rs1_), 3'b000, 5'(rd_), 7'h13};
  endfunction
  function automatic logic [31:0] add(input int rd_, input int rs1_, input int rs2_);
    return {7'h00, 5'(rs2_), 5'(rs1_), 3'b000, 5'(rd_), 7'h33};
  endfunction
  function automatic logic [31:0] sub(input int rd_, input int rs1_, input int rs2_);
    return {7'h20, 5'(rs2_), 5'(rs1_), 3'b000, 5'(rd_), 7'h33};
  endfunction
  function automatic logic [31:0] lw(input int rd_, input int rs1_, input int imm);
    return {12'(imm), 5'(rs1_), 3'b010, 5'(rd_), 7'h03};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 10)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins;
    bit v, fl;
    int cnt_before;

    rst_n = 1'b0; id_valid = 1'b0; id_inst = '0; flush = 1'b0;
    model_reset();
    #1;
    chk("reset_fwd_rs1", 32'(fwd1), 0);
    chk("reset_fwd_rs2", 32'(fwd2), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_stall_cnt", 32'(cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: back-to-back ALU dependency
    issue(addi(5, 0, 1));
    issue(add(6, 5, 5));
    // 2: dependency two stages back
    issue(addi(5, 0, 2));
    issue(addi(0, 0, 0));
    issue(add(6, 5, 0));
    // 3: load-use
    issue(lw(5, 1, 0));
    issue(add(6, 5, 2));
    // 4: youngest wins; x0 never forwards
    issue(addi(5, 0, 3));
    issue(addi(5, 0, 4));
    issue(sub(7, 5, 5));
    issue(add(0, 1, 2));
    issue(add(8, 0, 0));
    // 5: flush on the load-use cycle
    cnt_before = m_cnt;
    issue(lw(5, 1, 0));
    step(1, add(6, 5, 0), 1);
    chk("flush_no_stall_cnt", 32'(cnt), 32'(cnt_before));
    issue(add(9, 5, 5));
    issue(addi(0, 0, 0));
    issue(add(9, 5, 5));

    // 6: five load-use pairs saturate the narrow counter
    cnt_before = m_cnt;
    for (int i = 0; i < 5; i++) begin
      issue(lw(5, 1, 0));
      issue(add(6, 5, 2));
    end
    @(negedge clk);
    chk("cnt_after_pairs", 32'(cnt), 32'(cnt_before + 5));
    chk("small_cnt_saturated", 32'(cntb), 3);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    model_advance(0, '0, 0);

    // Random traffic with stalls honoured by holding the ID instruction.
    e_stall = 0;
    for (int n = 0; n < 400; n++) begin
      if (!e_stall) begin
        ins = rand_inst();
        v   = ($urandom_range(0, 9) != 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      step(v, ins, fl);
    end

    // Asynchronous reset in the middle of a load-use stall.
    issue(lw(5, 1, 0));
    id_valid = 1'b1; id_inst = add(6, 5, 2); flush = 1'b0;
    model_expect(1, add(6, 5, 2), 0);
    #2;
    chk("pre_reset_stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_fwd_rs1", 32'(fwd1), 0);
    chk("async_rst_fwd_rs2", 32'(fwd2), 0);
    chk("async_rst_stall", 32'(stall), 0);
    chk("async_rst_stall_cnt", 32'(cnt), 0);
    chk("async_rst_small_cnt", 32'(cntb), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(add(6, 5, 2));
    issue(add(7, 6, 6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
